// File: rtl/snake_sprite_sequencer_if.sv
// Pixel-side bus between the video timing/colour mux and the snake sprite sequencer.
// The master drives the pixel position and snake state; the slave returns the ROM address and the aligned hit flag.
interface snake_sprite_sequencer_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned ANIM_W = 1
);
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank;
    logic              vs;
    logic              enable;
    logic              moving;
    logic [9:0]        snake_x;
    logic [9:0]        snake_y;
    logic [1:0]        dir_in;
    logic [ADDR_W-1:0] rom_address;
    logic              hit;
    logic [ANIM_W-1:0] anim_frame;
    logic [1:0]        dir_cur;

    modport master (
        output DrawX, DrawY, blank, vs, enable, moving, snake_x, snake_y, dir_in,
        input  rom_address, hit, anim_frame, dir_cur
    );

    modport slave (
        input  DrawX, DrawY, blank, vs, enable, moving, snake_x, snake_y, dir_in,
        output rom_address, hit, anim_frame, dir_cur
    );
endinterface

// File: rtl/snake_sprite_sequencer.sv
// Snake sprite ROM sequencer: latches position/direction once per frame, steps the walk animation
// on a frame divider, and produces a per-pixel ROM address with a hit flag aligned to the ROM data.
module snake_sprite_sequencer #(
    parameter int unsigned SPR_W      = 21,
    parameter int unsigned SPR_H      = 45,
    parameter int unsigned NUM_DIRS   = 4,
    parameter int unsigned NUM_FRAMES = 2,
    parameter int unsigned FRAME_DIV  = 8,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned ADDR_W     = 13
) (
    input  logic                     vga_clk,
    input  logic                     reset,
    snake_sprite_sequencer_if.slave  bus
);
    localparam int unsigned ANIM_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int unsigned DIV_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned HIT_D     = 1 + ROM_LAT;
    localparam int unsigned SPR_AREA  = SPR_W * SPR_H;
    localparam int unsigned ROM_WORDS = NUM_DIRS * NUM_FRAMES * SPR_AREA;

    logic              vs_q;
    logic [9:0]        x_l_q, x_l_d;
    logic [9:0]        y_l_q, y_l_d;
    logic [1:0]        dir_q, dir_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [ANIM_W-1:0] anim_q, anim_d;
    logic [ADDR_W-1:0] rom_q, rom_d;
    logic [HIT_D-1:0]  hit_pipe_q, hit_pipe_d;

    logic              fs_c;
    logic              in_box_c;
    logic [9:0]        dx_c, dy_c;
    logic [ADDR_W-1:0] frame_idx_c, addr_c;

    // Frame start: falling edge of vs against its registered copy
    assign fs_c = vs_q & ~bus.vs;

    // Per-frame latch of position/direction and animation stepping
    always_comb begin
        x_l_d  = x_l_q;
        y_l_d  = y_l_q;
        dir_d  = dir_q;
        div_d  = div_q;
        anim_d = anim_q;
        if (fs_c) begin
            x_l_d = bus.snake_x;
            y_l_d = bus.snake_y;
            dir_d = bus.dir_in;
            if (bus.enable && bus.moving) begin
                if (bus.dir_in != dir_q) begin
                    div_d  = '0;
                    anim_d = '0;
                end else if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                    div_d  = '0;
                    anim_d = (anim_q == ANIM_W'(NUM_FRAMES - 1)) ? '0 : anim_q + ANIM_W'(1);
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        end
    end

    // Hit window uses 11-bit upper bounds so a sprite near the right/bottom edge cannot wrap
    always_comb begin
        in_box_c = bus.blank & bus.enable
                 & (bus.DrawX >= x_l_q) & ({1'b0, bus.DrawX} < ({1'b0, x_l_q} + 11'(SPR_W)))
                 & (bus.DrawY >= y_l_q) & ({1'b0, bus.DrawY} < ({1'b0, y_l_q} + 11'(SPR_H)));
        dx_c        = bus.DrawX - x_l_q;
        dy_c        = bus.DrawY - y_l_q;
        frame_idx_c = ADDR_W'(dir_q) * ADDR_W'(NUM_FRAMES) + ADDR_W'(anim_q);
        addr_c      = frame_idx_c * ADDR_W'(SPR_AREA) + ADDR_W'(dy_c) * ADDR_W'(SPR_W) + ADDR_W'(dx_c);
        rom_d       = '0;
        if (in_box_c && (32'(addr_c) < ROM_WORDS)) begin
            rom_d = addr_c;
        end
        hit_pipe_d = HIT_D'({hit_pipe_q, in_box_c});
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            vs_q       <= 1'b1;
            x_l_q      <= '0;
            y_l_q      <= '0;
            dir_q      <= '0;
            div_q      <= '0;
            anim_q     <= '0;
            rom_q      <= '0;
            hit_pipe_q <= '0;
        end else begin
            vs_q       <= bus.vs;
            x_l_q      <= x_l_d;
            y_l_q      <= y_l_d;
            dir_q      <= dir_d;
            div_q      <= div_d;
            anim_q     <= anim_d;
            rom_q      <= rom_d;
            hit_pipe_q <= hit_pipe_d;
        end
    end

    assign bus.rom_address = rom_q;
    assign bus.hit         = hit_pipe_q[HIT_D-1];
    assign bus.anim_frame  = anim_q;
    assign bus.dir_cur     = dir_q;
endmodule

// File: tb/tb_snake_sprite_sequencer.sv
// Directed bench for snake_sprite_sequencer with default parameters (21x45 sprite, 2 frames, divider 8, ROM latency 1).
module tb_snake_sprite_sequencer;
    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    snake_sprite_sequencer_if #(.ADDR_W(13), .ANIM_W(1)) bus ();

    snake_sprite_sequencer dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // Hold a pixel for two cycles: address appears after one, hit after two
    task automatic pix(input string tag, input int x, input int y, input int exp_addr, input logic exp_hit);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        tick();
        chk({tag, "_addr"}, 32'(bus.rom_address), 32'(exp_addr));
        tick();
        chk({tag, "_hit"}, 32'(bus.hit), 32'(exp_hit));
    endtask

    // One frame-start pulse with blanking asserted
    task automatic fs();
        logic b;
        b = bus.blank;
        bus.blank = 1'b0;
        bus.vs = 1'b0;
        tick();
        bus.vs = 1'b1;
        tick();
        bus.blank = b;
    endtask

    initial begin
        bus.DrawX   = '0;
        bus.DrawY   = '0;
        bus.blank   = 1'b1;
        bus.vs      = 1'b1;
        bus.enable  = 1'b1;
        bus.moving  = 1'b0;
        bus.snake_x = 10'd100;
        bus.snake_y = 10'd50;
        bus.dir_in  = 2'd0;
        tick();
        tick();
        chk("rst_addr", 32'(bus.rom_address), 32'd0);
        chk("rst_hit",  32'(bus.hit), 32'd0);
        chk("rst_anim", 32'(bus.anim_frame), 32'd0);
        chk("rst_dir",  32'(bus.dir_cur), 32'd0);
        reset = 1'b0;

        // Before any frame start the sprite sits at the origin
        pix("origin", 0, 0, 0, 1'b1);
        pix("unlatched", 100, 50, 0, 1'b0);

        // Latch position (100,50), dir 0, frame 0
        fs();
        chk("fs1_dir",  32'(bus.dir_cur), 32'd0);
        chk("fs1_anim", 32'(bus.anim_frame), 32'd0);
        pix("in_103_52",  103, 52, 45, 1'b1);
        pix("right_edge", 120, 52, 62, 1'b1);
        pix("right_out",  121, 52, 0, 1'b0);
        pix("left_out",   99, 52, 0, 1'b0);
        pix("bottom_row", 100, 94, 924, 1'b1);
        pix("bottom_out", 100, 95, 0, 1'b0);

        // Direction change restarts animation, then 8 frames per step
        bus.dir_in = 2'd2;
        bus.moving = 1'b1;
        fs();
        chk("dirchg_dir",  32'(bus.dir_cur), 32'd2);
        chk("dirchg_anim", 32'(bus.anim_frame), 32'd0);
        repeat (7) fs();
        chk("fs8_anim", 32'(bus.anim_frame), 32'd0);
        fs();
        chk("fs9_anim", 32'(bus.anim_frame), 32'd1);
        pix("dir2_f1", 100, 50, 4725, 1'b1);

        // Divider advances 3, holds for 20 frames while stopped, then finishes the step
        repeat (3) fs();
        bus.moving = 1'b0;
        repeat (20) fs();
        chk("hold_anim", 32'(bus.anim_frame), 32'd1);
        bus.moving = 1'b1;
        repeat (4) fs();
        chk("resume4_anim", 32'(bus.anim_frame), 32'd1);
        fs();
        chk("resume5_wrap", 32'(bus.anim_frame), 32'd0);

        // Mid-frame position change takes effect only at the next frame start
        bus.snake_x = 10'd300;
        pix("midframe_old", 100, 50, 3780, 1'b1);
        pix("midframe_new", 300, 50, 0, 1'b0);
        bus.moving = 1'b0;
        fs();
        pix("latched_new", 300, 50, 3780, 1'b1);
        pix("latched_old", 100, 50, 0, 1'b0);

        // Blanking and disable suppress the sprite
        bus.blank = 1'b0;
        pix("blanked", 300, 50, 0, 1'b0);
        bus.blank  = 1'b1;
        bus.enable = 1'b0;
        pix("disabled", 300, 50, 0, 1'b0);
        bus.enable = 1'b1;

        // vs held low for ~3 frames gives exactly one frame start
        bus.moving = 1'b1;
        bus.blank  = 1'b0;
        bus.vs     = 1'b0;
        tick();
        bus.snake_x = 10'd400;
        repeat (30) tick();
        bus.vs    = 1'b1;
        tick();
        bus.blank = 1'b1;
        pix("vslow_no_relatch", 400, 50, 0, 1'b0);
        pix("vslow_old_pos", 300, 50, 3780, 1'b1);
        repeat (6) fs();
        chk("single_fs_anim0", 32'(bus.anim_frame), 32'd0);
        fs();
        chk("single_fs_anim1", 32'(bus.anim_frame), 32'd1);

        // Asynchronous reset while the sprite is being hit
        pix("pre_reset", 400, 50, 4725, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_hit",  32'(bus.hit), 32'd0);
        chk("async_anim", 32'(bus.anim_frame), 32'd0);
        chk("async_dir",  32'(bus.dir_cur), 32'd0);
        chk("async_addr", 32'(bus.rom_address), 32'd0);
        tick();
        reset = 1'b0;
        pix("post_reset_old", 400, 50, 0, 1'b0);
        pix("post_reset_origin", 0, 0, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
